// File: rtl/cra_diag_seq_pkg.sv
// rtl/cra_diag_seq_pkg.sv - shared states, DIAG function codes and widths for cra_diag_seq
package cra_diag_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, ADRH, ADRL, W00, W20, W40, W60, RD5, RD0, DONE
    } state_t;

    // DIAG[4:6] function codes
    localparam logic [2:0] DIAG_LD_ADRH = 3'd2;
    localparam logic [2:0] DIAG_LD_ADRL = 3'd1;
    localparam logic [2:0] DIAG_LD_W00  = 3'd7;
    localparam logic [2:0] DIAG_LD_W20  = 3'd6;
    localparam logic [2:0] DIAG_LD_W40  = 3'd5;
    localparam logic [2:0] DIAG_LD_W60  = 3'd4;
    localparam logic [2:0] DIAG_RD_C5   = 3'd4;
    localparam logic [2:0] DIAG_RD_C0   = 3'd5;

    localparam int SEG_W = 20;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_READ = 1'b1;

endpackage

// File: rtl/cra_diag_step_timer.sv
// rtl/cra_diag_step_timer.sv - per-step setup/strobe cycle counter with freeze
module cra_diag_step_timer #(
    parameter int SETUP_CYC = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic run,
    input  logic freeze,
    output logic strobe
);

    logic [2:0] cnt;

    // Strobe lands on the cycle after SETUP_CYC granted setup cycles.
    assign strobe = run && !freeze && (cnt == 3'(SETUP_CYC));

    // A lost grant holds the step where it is but rewinds the setup count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (!run || freeze || strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/cra_diag_seq.sv
// rtl/cra_diag_seq.sv - CRAM load / CRADR read diagnostic sequencer over EBUS
// Build option: CRA_DIAG_READBACK_EN enables the READ (CRADR readback) sequence.
module cra_diag_seq
    import cra_diag_seq_pkg::*;
#(
    parameter int SETUP_CYC = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic        op,
    input  logic [0:10] addr,
    input  logic [0:79] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [0:11] rdata,
    output logic        ebusReq,
    input  logic        ebusGrant,
    output logic [0:35] ebusOut,
    input  logic [0:35] ebusIn,
    output logic [4:6]  diag,
    output logic        loadFunc05x,
    output logic        readFunc14x
);

`ifdef CRA_DIAG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    state_t      state, state_nxt;
    logic        op_q;
    logic [0:10] addr_q;
    logic [0:79] wdata_q;
    logic [0:5]  rd_lo_q;
    logic        step_active;
    logic        load_step;
    logic        read_step;
    logic        strobe;
    logic        unused_ebus;

    assign unused_ebus = ^ebusIn[6:35];

    assign load_step   = (state == ADRH) || (state == ADRL) || (state == W00) ||
                         (state == W20)  || (state == W40)  || (state == W60);
    assign read_step   = (state == RD5) || (state == RD0);
    assign step_active = load_step || read_step;

    cra_diag_step_timer #(.SETUP_CYC(SETUP_CYC)) u_timer (
        .CLK    (CLK),
        .RESET  (RESET),
        .run    (step_active),
        .freeze (!ebusGrant),
        .strobe (strobe)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            op_q    <= OP_LOAD;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_lo_q <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            // rdata only changes once the whole CRADR has been read
            if (state == RD5 && strobe) begin
                rd_lo_q <= ebusIn[0:5];
            end
            if (state == RD0 && strobe) begin
                rdata <= {ebusIn[0:5], rd_lo_q};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = (op == OP_READ) ? (READBACK ? RD5 : DONE) : ADRH;
            ADRH: if (strobe) state_nxt = ADRL;
            ADRL: if (strobe) state_nxt = W00;
            W00:  if (strobe) state_nxt = W20;
            W20:  if (strobe) state_nxt = W40;
            W40:  if (strobe) state_nxt = W60;
            W60:  if (strobe) state_nxt = DONE;
            RD5:  if (strobe) state_nxt = RD0;
            RD0:  if (strobe) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        diag    = 3'd0;
        ebusOut = '0;
        case (state)
            ADRH: begin diag = DIAG_LD_ADRH; ebusOut[1:5] = addr_q[0:4];  end
            ADRL: begin diag = DIAG_LD_ADRL; ebusOut[0:5] = addr_q[5:10]; end
            W00:  begin diag = DIAG_LD_W00;  ebusOut[0:SEG_W-1] = wdata_q[0*SEG_W +: SEG_W]; end
            W20:  begin diag = DIAG_LD_W20;  ebusOut[0:SEG_W-1] = wdata_q[1*SEG_W +: SEG_W]; end
            W40:  begin diag = DIAG_LD_W40;  ebusOut[0:SEG_W-1] = wdata_q[2*SEG_W +: SEG_W]; end
            W60:  begin diag = DIAG_LD_W60;  ebusOut[0:SEG_W-1] = wdata_q[3*SEG_W +: SEG_W]; end
            RD5:  diag = DIAG_RD_C5;
            RD0:  diag = DIAG_RD_C0;
            default: ;
        endcase
    end

    assign busy        = step_active;
    assign ebusReq     = step_active;
    assign done        = (state == DONE);
    assign err         = done && (op_q == OP_READ) && !READBACK;
    assign loadFunc05x = load_step && strobe;
    assign readFunc14x = read_step && ebusGrant;

endmodule

// File: tb/tb_cra_diag_seq.sv
// tb/tb_cra_diag_seq.sv - directed self-checking bench for cra_diag_seq
module tb_cra_diag_seq;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req;
    logic        op;
    logic [0:10] addr;
    logic [0:79] wdata;
    logic        busy, done, err;
    logic [0:11] rdata;
    logic        ebusReq;
    logic        ebusGrant;
    logic [0:35] ebusOut;
    logic [0:35] ebusIn;
    logic [4:6]  diag;
    logic        loadFunc05x, readFunc14x;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]  stb_diag [0:7];
    logic [0:35] stb_eo   [0:7];
    localparam logic [2:0] EXP_DG [0:5] = '{3'd2, 3'd1, 3'd7, 3'd6, 3'd5, 3'd4};
    logic [35:0] exp_eo [0:5];

    cra_diag_seq #(.SETUP_CYC(1)) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .ebusReq(ebusReq), .ebusGrant(ebusGrant), .ebusOut(ebusOut), .ebusIn(ebusIn),
        .diag(diag), .loadFunc05x(loadFunc05x), .readFunc14x(readFunc14x)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ebusReq"}, ebusReq, 0);
        chk({tag, "_load"}, loadFunc05x, 0);
        chk({tag, "_read"}, readFunc14x, 0);
        chk({tag, "_diag"}, diag, 0);
        chk({tag, "_ebusOut"}, ebusOut, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // Runs one LOAD; grant low for cycles [d0, d0+dlen); req re-pulsed at cycle pulse_at.
    task automatic do_load(input logic [0:10] a, input logic [0:79] w, input int d0,
                           input int dlen, input int pulse_at, output int lat, output int nstb);
        lat  = -1;
        nstb = 0;
        @(negedge CLK); req = 1'b1; op = 1'b0; addr = a; wdata = w;
        @(negedge CLK); req = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            ebusGrant = !(n >= d0 && n < d0 + dlen);
            req = (n == pulse_at);
            #1;
            if (n == 1) chk("busy_after_accept", busy, 1);
            if (!ebusGrant) chk("strobe_while_ungranted", loadFunc05x, 0);
            if (loadFunc05x && nstb < 8) begin
                stb_diag[nstb] = diag;
                stb_eo[nstb]   = ebusOut;
                nstb++;
            end
            if (done) begin
                lat = n;
                chk("done_busy_low", busy, 0);
                chk("done_ebusReq_low", ebusReq, 0);
                chk("load_no_err", err, 0);
                break;
            end
            @(negedge CLK);
        end
        req = 1'b0;
        ebusGrant = 1'b1;
    endtask

    task automatic check_strobes(input string tag, input int nstb);
        chk({tag, "_strobe_count"}, nstb, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_diag%0d", tag, i), stb_diag[i], EXP_DG[i]);
            chk($sformatf("%s_ebus%0d", tag, i), stb_eo[i], exp_eo[i]);
        end
    endtask

    int lat, nstb, extra;

    initial begin
        RESET = 1'b1; req = 1'b0; op = 1'b0; addr = '0; wdata = '0;
        ebusGrant = 1'b1; ebusIn = '0;
        repeat (3) @(negedge CLK);
        #1;
        chk_outputs_zero("reset");
        @(negedge CLK); RESET = 1'b0;

        // Basic LOAD, addr 1234, wdata 1
        exp_eo = '{36'o120000000000, 36'o340000000000, 36'h0, 36'h0, 36'h0, 36'h000010000};
        do_load(11'o1234, 80'h1, 0, 0, 0, lat, nstb);
        chk("load1_latency", lat, 13);
        check_strobes("load1", nstb);

        // Boundary address, distinct segments
        exp_eo = '{36'o370000000000, 36'o770000000000, 36'h123450000,
                   36'h6789A0000, 36'hBCDEF0000, 36'h012340000};
        do_load(11'o3777, 80'h12345_6789A_BCDEF_01234, 0, 0, 0, lat, nstb);
        chk("load2_latency", lat, 13);
        check_strobes("load2", nstb);

        // Grant lost for 3 cycles at the W40 strobe: +3 idle, +1 setup restart
        do_load(11'o3777, 80'h12345_6789A_BCDEF_01234, 10, 3, 0, lat, nstb);
        chk("drop_latency", lat, 17);
        check_strobes("drop", nstb);

        // req pulsed while busy is ignored and does not queue
        do_load(11'o3777, 80'h12345_6789A_BCDEF_01234, 0, 0, 5, lat, nstb);
        chk("busyreq_latency", lat, 13);
        extra = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge CLK); #1;
            if (done || busy) extra++;
        end
        chk("busyreq_no_queue", extra, 0);

        // req held high: one idle cycle with busy low before re-acceptance
        @(negedge CLK); req = 1'b1; op = 1'b0; addr = 11'o0001; wdata = 80'h5;
        lat = -1;
        for (int n = 0; n <= 40; n++) begin
            @(negedge CLK); #1;
            if (done) begin lat = n + 1; break; end
        end
        chk("held_req_latency", lat, 13);
        chk("held_req_done_busy", busy, 0);
        @(negedge CLK); #1;
        chk("held_req_idle_busy", busy, 0);
        @(negedge CLK); #1;
        chk("held_req_reaccept_busy", busy, 1);
        req = 1'b0;
        lat = -1;
        for (int n = 0; n <= 40; n++) begin
            @(negedge CLK); #1;
            if (done) begin lat = n; break; end
        end
        chk("held_req_second_done", (lat >= 0), 1);

        // RESET during W20
        @(negedge CLK); req = 1'b1; op = 1'b0; addr = 11'o1234; wdata = 80'h1;
        @(negedge CLK); req = 1'b0;
        repeat (6) @(negedge CLK);
        #1;
        chk("pre_reset_in_w20", diag, 3'd6);
        RESET = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        extra = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK); #1;
            if (done) extra++;
        end
        chk("midreset_no_done", extra, 0);
        @(negedge CLK); RESET = 1'b0;
        exp_eo = '{36'o120000000000, 36'o340000000000, 36'h0, 36'h0, 36'h0, 36'h000010000};
        do_load(11'o1234, 80'h1, 0, 0, 0, lat, nstb);
        chk("post_reset_latency", lat, 13);
        check_strobes("post_reset", nstb);

`ifdef CRA_DIAG_READBACK_EN
        // READ: 52 in RD5, 43 in RD0 gives rdata 4352
        @(negedge CLK); req = 1'b1; op = 1'b1;
        @(negedge CLK); req = 1'b0;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            ebusIn = (n <= 2) ? {6'o52, 30'h0} : {6'o43, 30'h0};
            #1;
            if (n <= 4) chk($sformatf("read_func14x_c%0d", n), readFunc14x, 1);
            if (done) begin lat = n; break; end
            @(negedge CLK);
        end
        chk("read_latency", lat, 5);
        chk("read_no_err", err, 0);
        chk("read_rdata", rdata, 12'o4352);
        ebusIn = '0;
`else
        // READ without readback: immediate done+err, bus untouched
        @(negedge CLK); req = 1'b1; op = 1'b1;
        #1;
        chk("read_accept_ebusReq", ebusReq, 0);
        @(negedge CLK); req = 1'b0;
        #1;
        chk("read_done", done, 1);
        chk("read_err", err, 1);
        chk("read_busy", busy, 0);
        chk("read_ebusReq", ebusReq, 0);
        chk("read_rdata_unchanged", rdata, 0);
        @(negedge CLK); #1;
        chk("read_done_one_cycle", done, 0);
        chk("read_err_one_cycle", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cra_diag_seq.md
CRA_DIAG_SEQ -- requirements
Module: cra_diag_seq

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1, giving EBUS data setup cycles before each load strobe (range 1..7).
REQ-002 SHALL have ports: CLK  in  1  sole clock; RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: req  in  1  requester start; op  in  1  0=LOAD CRAM word, 1=READ CRADR; addr  in  11  CRAM address [0:10]; wdata  in  80  CRAM word [0:79].
REQ-004 SHALL have ports: busy  out  1  sequence in progress; done  out  1  one-cycle completion pulse; err  out  1  one-cycle error pulse, coincident with done; rdata  out  12  {DISP_PARITY, CRADR[0:10]}.
REQ-005 SHALL have ports: ebusReq  out  1  EBUS ownership request; ebusGrant  in  1  EBUS granted; ebusOut  out  36  EBUS data [0:35] driven; ebusIn  in  36  EBUS data sampled.
REQ-006 SHALL have ports: diag  out  3  DIAG[4:6] function code; loadFunc05x  out  1  DIAG_LOAD_FUNC_05x strobe; readFunc14x  out  1  DIAG_READ_FUNC_14x enable.

Function
REQ-007 SHALL accept req only in IDLE; the accepted op, addr and wdata are captured that cycle, and busy asserts the next cycle.
REQ-008 SHALL raise ebusReq on leaving IDLE and hold it until done; no step advances in a cycle where ebusGrant=0, and loadFunc05x and readFunc14x are forced to 0 in that cycle.
REQ-009 LOAD step order: ADRH (diag=2, ebusOut[1:5]=addr[0:4]), ADRL (diag=1, ebusOut[0:5]=addr[5:10]), W00 (diag=7, wdata[0:19]), W20 (diag=6, wdata[20:39]), W40 (diag=5, wdata[40:59]), W60 (diag=4, wdata[60:79]), then DONE.
REQ-010 SHALL place each 20-bit segment on ebusOut[0:19]; all unused ebusOut bits SHALL be 0.
REQ-011 Each LOAD step: SETUP_CYC granted cycles with data and diag stable, then one strobe cycle with loadFunc05x=1, then the next step. Total LOAD latency is 6*(SETUP_CYC+1) granted cycles, plus 1 DONE cycle.
REQ-012 READ step order: RD5 (diag=4, readFunc14x=1 for SETUP_CYC+1 cycles, sample ebusIn[0:5] into rdata[6:11] on the last cycle), RD0 (diag=5, sample ebusIn[0:5] into {rdata[0], rdata[1:5]}), then DONE.
REQ-013 DONE SHALL last one cycle: done=1, busy=0, and ebusReq drops in the same cycle. The FSM returns to IDLE, and req may be accepted in the following cycle.
REQ-014 rdata SHALL hold its last sampled value until the next READ completes.
REQ-015 ebusGrant dropping mid-step SHALL freeze the step counter and state; the strobe cycle SHALL re-execute when grant returns, and the setup count SHALL restart.
REQ-016 req asserted while busy SHALL be ignored and SHALL NOT queue.

Reset
REQ-017 RESET SHALL force IDLE at any time, including mid-sequence, with no done pulse, and SHALL clear: busy, done, err, ebusReq, loadFunc05x, readFunc14x, diag=0, ebusOut=0, rdata=0.

Configuration
REQ-018 With macro CRA_DIAG_READBACK_EN defined, READ behaves per REQ-012.
REQ-019 Without CRA_DIAG_READBACK_EN, an accepted READ SHALL go directly to DONE with err=1, never assert ebusReq, and leave rdata unchanged; LOAD is unaffected.

Structure
REQ-020 A shared package SHALL hold: the state enum (IDLE, ADRH, ADRL, W00, W20, W40, W60, RD5, RD0, DONE); the DIAG[4:6] function-code constants; and the segment width 20.
REQ-021 One sub-module, cra_diag_step_timer, SHALL hold the setup/strobe cycle counter with freeze input; all else stays in cra_diag_seq.

Verification
REQ-022 SETUP_CYC=1, grant tied 1, LOAD addr=11'o1234, wdata=80'h1: diag sequence 2,1,7,6,5,4; ebusOut[1:5]=5'o12 then ebusOut[0:5]=6'o34; six loadFunc05x pulses; done exactly 13 cycles after busy rises.
REQ-023 Grant dropped for 3 cycles during W40 strobe: no strobe while grant=0; W40 strobe reissued; total latency grows by 3 plus the setup restart.
REQ-024 READ with CRA_DIAG_READBACK_EN, ebusIn[0:5]=6'o52 in RD5 then 6'o43 in RD0: rdata=12'o4352, done and no err.
REQ-025 READ without the macro: done and err on the same cycle; ebusReq never asserts; rdata unchanged.
REQ-026 RESET asserted during W20: all outputs zero immediately; no done; a new LOAD accepted after RESET release completes normally.
REQ-027 req pulsed during a busy LOAD: ignored; exactly one done; busy low for at least 1 cycle before the next acceptance.
